instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Fetch stage of the 8-bit simple CPU: holds the 16-bit program counter, reads one 16-bit instruction as two consecutive bytes from the byte-wide instruction memory, and presents it on `IROut` to the controller. It sits directly upstream of the controller, which consumes `IROut`, requests fetches, and redirects the PC on jumps. `IROut` never shows a half-fetched instruction; a new word is committed atomically and flagged with a one-cycle `irValid` pulse.

## Interface
- `RESET_PC`, default 16'h0000, PC value loaded on reset.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `nRst`  in  1  asynchronous reset, active-low.
- `fetchReq`  in  1  start a fetch at the current PC; sampled only in IDLE.
- `jumpEn`  in  1  load PC from `jumpAddr`; sampled only in IDLE.
- `jumpAddr`  in  16  jump target byte address.
- `iData`  in  8  instruction memory read data, valid the cycle after `iRead`.
- `iRead`  out  1  instruction memory read strobe.
- `iAddr`  out  16  instruction memory byte address.
- `IROut`  out  16  committed instruction: {high byte, low byte}.
- `PCOut`  out  16  current PC (address of the next instruction).
- `irValid`  out  1  one-cycle pulse: `IROut` just updated.
- `busy`  out  1  fetch in progress (state != IDLE).

## Operation
- States: IDLE, RDL, RDH, CAPH.
- IDLE: `iRead`=0, `iAddr`=PC. On the edge:
  - `jumpEn`=1 sets PC to `jumpAddr`.
  - `fetchReq`=1 moves to RDL.
  - Both high: PC loads `jumpAddr` and the fetch starts from `jumpAddr`.
- RDL: `iRead`=1, `iAddr`=PC (low byte). Moves to RDH.
- RDH: `iRead`=1, `iAddr`=PC+1 (high byte, mod 2^16). Edge: staging register <= `iData`. Moves to CAPH.
- CAPH: `iRead`=0, `iAddr`=PC. Edge:
  - `IROut` <= {`iData`, staging}.
  - PC <= PC+2 (mod 2^16).
  - `irValid` <= 1.
  - Moves to IDLE.
- Byte order is little-endian: low byte at PC, high byte at PC+1. Odd PC values are legal.
- `fetchReq` and `jumpEn` are ignored while `busy`=1. Nothing is queued; the controller re-asserts them after `busy` falls.
- `IROut` and `PCOut` hold their values throughout a fetch and change only on the CAPH edge (or on a jump edge for `PCOut`).
- Wrap-around: with PC=16'hFFFF, the bytes come from FFFF and 0000, and the next PC is 16'h0001. With PC=16'hFFFE, the next PC is 16'h0000.
- Reset (asynchronous, any state):
  - State = IDLE, PC = `RESET_PC`.
  - `IROut` = 16'h0000, staging = 8'h00.
  - `irValid` = 0, `busy` = 0, `iRead` = 0, `iAddr` = `RESET_PC`.
  - A fetch interrupted by reset produces no `irValid` pulse and no `IROut` change.

## Timing
- Let edge E0 be the edge that samples `fetchReq` in IDLE.
- RDL occupies E0–E1, RDH occupies E1–E2, and CAPH occupies E2–E3.
- `IROut` is new and `irValid`=1 in the cycle after E3; state is already IDLE in that cycle.
- Latency is 3 edges from request to `irValid`.
- If `fetchReq` is held high in the `irValid` cycle, the next fetch starts at E4. Maximum throughput is one instruction per 4 cycles.
- `busy` is high for exactly 3 cycles per fetch.
- `irValid` is exactly one cycle wide. It is never asserted back-to-back.
- Memory contract: synchronous read, 1-cycle latency. `iData` in cycle N+1 corresponds to `iAddr` in cycle N with `iRead`=1.

## Test plan
- Reset: assert `nRst`=0 mid-RDH with `RESET_PC`=16'h0010.
  - Immediately: `busy`=0, `iRead`=0, `PCOut`=16'h0010, `IROut`=16'h0000.
  - After release: no `irValid` pulse.
- Single fetch: memory[0]=8'hFF, [1]=8'h89, PC=0, pulse `fetchReq`.
  - Cycles after E0: `iAddr` 0, then 1.
  - Cycle after E3: `IROut`=16'h89FF, `irValid`=1 for one cycle, `PCOut`=2.
- Back-to-back: hold `fetchReq`=1 over 3 instructions at 0, 2, 4.
  - `irValid` pulses every 4 cycles, `PCOut` ends at 6.
  - `IROut` is stable between pulses.
- Jump with fetch: in IDLE, `jumpEn`=1, `jumpAddr`=16'h0101, `fetchReq`=1 together.
  - Bytes are read from 0101 and 0102, `PCOut`=16'h0103 afterwards.
- Ignored inputs: pulse `jumpEn` (`jumpAddr`=16'h4000) and `fetchReq` during RDH.
  - PC advances normally by 2.
  - No second fetch occurs.
  - `PCOut` != 16'h4000.
- Wrap: PC=16'hFFFF, memory[FFFF]=8'h12, [0000]=8'h34.
  - `IROut`=16'h3412, `PCOut`=16'h0001.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Controller/memory-facing bundle of the fetch stage.
// The master side is the controller plus instruction memory; the slave side is the fetch unit.
interface instr_fetch_unit_if;
   logic        fetchReq;
   logic        jumpEn;
   logic [15:0] jumpAddr;
   logic [7:0]  iData;
   logic        iRead;
   logic [15:0] iAddr;
   logic [15:0] IROut;
   logic [15:0] PCOut;
   logic        irValid;
   logic        busy;

   modport master (
      output fetchReq, jumpEn, jumpAddr, iData,
      input  iRead, iAddr, IROut, PCOut, irValid, busy
   );

   modport slave (
      input  fetchReq, jumpEn, jumpAddr, iData,
      output iRead, iAddr, IROut, PCOut, irValid, busy
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads a little-endian 16-bit instruction as two bytes at PC and PC+1,
// commits it atomically to IROut with a one-cycle irValid pulse, then advances PC by 2.
module instr_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic              clock,
   input  logic              nRst,
   instr_fetch_unit_if.slave bus,
   output logic [1:0]        dbgState
);

   // Request protocol: fetchReq/jumpEn are sampled only while busy=0 (IDLE); nothing is
   // queued while busy=1, and completion is the single irValid cycle after busy falls.
   typedef enum logic [1:0] {IDLE = 2'd0, RDL = 2'd1, RDH = 2'd2, CAPH = 2'd3} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] pc;
   logic [15:0] ir;
   logic [7:0]  stage;
   logic        ir_valid;
   logic        rd;
   logic [15:0] addr;

   always_ff @(posedge clock or negedge nRst) begin
      if (!nRst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.fetchReq) state_nxt = RDL;
         RDL:  state_nxt = RDH;
         RDH:  state_nxt = CAPH;
         CAPH: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rd   = 1'b0;
      addr = pc;
      case (state)
         RDL: rd = 1'b1;
         RDH: begin
            rd   = 1'b1;
            addr = pc + 16'd1;
         end
         default: begin
            rd   = 1'b0;
            addr = pc;
         end
      endcase
   end

   // A jump in IDLE lands in pc before RDL, so a simultaneous fetch reads from the target.
   always_ff @(posedge clock or negedge nRst) begin
      if (!nRst) begin
         pc       <= RESET_PC;
         ir       <= 16'h0000;
         stage    <= 8'h00;
         ir_valid <= 1'b0;
      end else begin
         ir_valid <= (state == CAPH);
         case (state)
            IDLE: if (bus.jumpEn) pc <= bus.jumpAddr;
            RDH:  stage <= bus.iData;
            CAPH: begin
               ir <= {bus.iData, stage};
               pc <= pc + 16'd2;
            end
            default: ;
         endcase
      end
   end

   assign bus.iRead   = rd;
   assign bus.iAddr   = addr;
   assign bus.IROut   = ir;
   assign bus.PCOut   = pc;
   assign bus.irValid = ir_valid;
   assign bus.busy    = (state != IDLE);
   assign dbgState    = state;

endmodule
